// File: rtl/sdram_arb_pkg.sv
// Shared types and defaults for the two-port SDRAM arbiter.
package sdram_arb_pkg;

   localparam int AW_DEF           = 32'sd25;
   localparam int DW_DEF           = 32'sd8;
   localparam int TIMEOUT_DEF      = 32'sd255;
   localparam int WR_BURST_MAX_DEF = 32'sd4;

   // Width of the controller-stall watchdog counter.
   localparam int TMO_W = 32'sd8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } arb_state_e;

   typedef enum logic {
      GNT_WR = 1'b0,
      GNT_RD = 1'b1
   } arb_gnt_e;

   // Last watchdog count value before abort; the limit is clamped into the
   // range the counter can represent so a bad parameter cannot disable it.
   function automatic logic [TMO_W-1:0] tmo_last(input int limit);
      int clamped;
      if (limit < 32'sd1) begin
         clamped = 32'sd1;
      end else if (limit > ((32'sd1 <<< TMO_W) - 32'sd1)) begin
         clamped = (32'sd1 <<< TMO_W) - 32'sd1;
      end else begin
         clamped = limit;
      end
      return TMO_W'(clamped - 32'sd1);
   endfunction

endpackage

// File: rtl/sdram_arb_slot.sv
// One-entry request buffer: captures a strobe into an empty slot (or into a
// slot being freed on the same edge), and flags strobes that hit a full slot.
module sdram_arb_slot
   import sdram_arb_pkg::*;
#(
   parameter int AW  = AW_DEF,
   parameter int DW  = DW_DEF,
   localparam int DWS = (DW > 32'sd0) ? DW : 32'sd1
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic           req,
   input  logic [AW-1:0]  req_addr,
   input  logic [DWS-1:0] req_data,
   input  logic           free,
   output logic           full,
   output logic [AW-1:0]  addr,
   output logic [DWS-1:0] data,
   output logic           overflow
);

   logic          accept_s;
   logic          full_d;
   logic          full_q;
   logic [AW-1:0] addr_d;
   logic [AW-1:0] addr_q;

   // Accept/drop decision and next slot contents.
   always_comb begin
      accept_s = req && (!full_q || free);
      overflow = req && full_q && !free;
      if (accept_s) begin
         full_d = 1'b1;
         addr_d = req_addr;
      end else if (free) begin
         full_d = 1'b0;
         addr_d = addr_q;
      end else begin
         full_d = full_q;
         addr_d = addr_q;
      end
   end

   // Slot occupancy and address storage.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         full_q <= 1'b0;
         addr_q <= '0;
      end else begin
         full_q <= full_d;
         addr_q <= addr_d;
      end
   end

   assign full = full_q;
   assign addr = addr_q;

   if (DW > 32'sd0) begin : g_data
      logic [DWS-1:0] data_d;
      logic [DWS-1:0] data_q;

      // Data follows the same capture rule as the address.
      always_comb begin
         if (accept_s) begin
            data_d = req_data;
         end else begin
            data_d = data_q;
         end
      end

      // Data storage.
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            data_q <= '0;
         end else begin
            data_q <= data_d;
         end
      end

      assign data = data_q;
   end else begin : g_nodata
      // Address-only slot (read port): data input is ignored.
      logic unused_data_s;
      assign unused_data_s = ^req_data;
      assign data          = '0;
   end

endmodule

// File: rtl/sdram_arbiter.sv
// Arbitrates the single SDRAM controller port between the ioctl download
// writer and the VFD artwork reader; one transaction in flight at a time,
// bounded write bursts while a read waits, and a watchdog on sd_ready.
module sdram_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int AW           = AW_DEF,
   parameter int DW           = DW_DEF,
   parameter int TIMEOUT      = TIMEOUT_DEF,
   parameter int WR_BURST_MAX = WR_BURST_MAX_DEF
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          wr_req,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   output logic          wr_wait,
   input  logic          rd_req,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_data,
   output logic          rd_valid,
   output logic          rd_busy,
   output logic [AW-1:0] sd_addr,
   output logic [DW-1:0] sd_din,
   output logic          sd_rd,
   output logic          sd_we,
   input  logic [DW-1:0] sd_dout,
   input  logic          sd_ready,
   output logic          err_timeout,
   output logic          err_overflow,
   input  logic          err_clr
);

   localparam int SW = $clog2(WR_BURST_MAX + 32'sd1);
   localparam logic [SW-1:0]    STARVE_MAX = SW'(WR_BURST_MAX);
   localparam logic [TMO_W-1:0] TMO_LAST   = tmo_last(TIMEOUT);

   // Slot interface
   logic          wr_full_s;
   logic [AW-1:0] wr_slot_addr_s;
   logic [DW-1:0] wr_slot_data_s;
   logic          wr_ovf_s;
   logic          wr_free_s;
   logic          rd_full_s;
   logic [AW-1:0] rd_slot_addr_s;
   logic [0:0]    unused_rd_slot_data_s;
   logic          rd_ovf_s;
   logic          rd_free_s;

   // Transaction bookkeeping
   logic          done_s;
   logic          tmo_hit_s;

   arb_state_e       state_d,        state_q;
   arb_gnt_e         gnt_d,          gnt_q;
   logic [SW-1:0]    starve_d,       starve_q;
   logic [TMO_W-1:0] tmo_d,          tmo_q;
   logic [AW-1:0]    sd_addr_d,      sd_addr_q;
   logic [DW-1:0]    sd_din_d,       sd_din_q;
   logic             sd_rd_d,        sd_rd_q;
   logic             sd_we_d,        sd_we_q;
   logic [DW-1:0]    rd_data_d,      rd_data_q;
   logic             rd_valid_d,     rd_valid_q;
   logic             err_timeout_d,  err_timeout_q;
   logic             err_overflow_d, err_overflow_q;

   sdram_arb_slot #(
      .AW (AW),
      .DW (DW)
   ) u_wr_slot (
      .clk      (clk),
      .reset_n  (reset_n),
      .req      (wr_req),
      .req_addr (wr_addr),
      .req_data (wr_data),
      .free     (wr_free_s),
      .full     (wr_full_s),
      .addr     (wr_slot_addr_s),
      .data     (wr_slot_data_s),
      .overflow (wr_ovf_s)
   );

   sdram_arb_slot #(
      .AW (AW),
      .DW (32'sd0)
   ) u_rd_slot (
      .clk      (clk),
      .reset_n  (reset_n),
      .req      (rd_req),
      .req_addr (rd_addr),
      .req_data (1'b0),
      .free     (rd_free_s),
      .full     (rd_full_s),
      .addr     (rd_slot_addr_s),
      .data     (unused_rd_slot_data_s),
      .overflow (rd_ovf_s)
   );

   // The granted slot is released on the edge that ends the transaction.
   assign wr_free_s = done_s && (gnt_q == GNT_WR);
   assign rd_free_s = done_s && (gnt_q == GNT_RD);

   // Next-state logic: grant selection, strobe sequencing, watchdog, flags.
   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      starve_d   = starve_q;
      tmo_d      = tmo_q;
      sd_addr_d  = sd_addr_q;
      sd_din_d   = sd_din_q;
      sd_rd_d    = 1'b0;
      sd_we_d    = 1'b0;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      done_s     = 1'b0;
      tmo_hit_s  = 1'b0;

      case (state_q)
         IDLE: begin
            if (wr_full_s && (!rd_full_s || (starve_q < STARVE_MAX))) begin
               gnt_d     = GNT_WR;
               sd_addr_d = wr_slot_addr_s;
               sd_din_d  = wr_slot_data_s;
               sd_we_d   = 1'b1;
               state_d   = ISSUE;
               // Only writes that overtake a waiting read count as starvation.
               if (rd_full_s) begin
                  if (starve_q < STARVE_MAX) begin
                     starve_d = starve_q + SW'(1);
                  end else begin
                     starve_d = starve_q;
                  end
               end else begin
                  starve_d = '0;
               end
            end else if (rd_full_s) begin
               gnt_d     = GNT_RD;
               sd_addr_d = rd_slot_addr_s;
               sd_rd_d   = 1'b1;
               starve_d  = '0;
               state_d   = ISSUE;
            end else begin
               state_d = IDLE;
            end
         end

         ISSUE: begin
            tmo_d   = '0;
            state_d = WAIT;
         end

         WAIT: begin
            if (sd_ready) begin
               done_s  = 1'b1;
               state_d = IDLE;
               case (gnt_q)
                  GNT_RD: begin
                     rd_data_d  = sd_dout;
                     rd_valid_d = 1'b1;
                  end
                  GNT_WR: begin
                     rd_data_d = rd_data_q;
                  end
                  default: begin
                     rd_data_d = rd_data_q;
                  end
               endcase
            end else if (tmo_q == TMO_LAST) begin
               // Controller stalled: abort and still answer a read so the
               // renderer is never left waiting.
               done_s    = 1'b1;
               tmo_hit_s = 1'b1;
               state_d   = IDLE;
               case (gnt_q)
                  GNT_RD: begin
                     rd_data_d  = '0;
                     rd_valid_d = 1'b1;
                  end
                  GNT_WR: begin
                     rd_data_d = rd_data_q;
                  end
                  default: begin
                     rd_data_d = rd_data_q;
                  end
               endcase
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // Sticky error flags; a new event outranks a simultaneous clear.
      if (tmo_hit_s) begin
         err_timeout_d = 1'b1;
      end else if (err_clr) begin
         err_timeout_d = 1'b0;
      end else begin
         err_timeout_d = err_timeout_q;
      end

      if (wr_ovf_s || rd_ovf_s) begin
         err_overflow_d = 1'b1;
      end else if (err_clr) begin
         err_overflow_d = 1'b0;
      end else begin
         err_overflow_d = err_overflow_q;
      end
   end

   // Arbiter FSM and all registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= IDLE;
         gnt_q          <= GNT_WR;
         starve_q       <= '0;
         tmo_q          <= '0;
         sd_addr_q      <= '0;
         sd_din_q       <= '0;
         sd_rd_q        <= 1'b0;
         sd_we_q        <= 1'b0;
         rd_data_q      <= '0;
         rd_valid_q     <= 1'b0;
         err_timeout_q  <= 1'b0;
         err_overflow_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         gnt_q          <= gnt_d;
         starve_q       <= starve_d;
         tmo_q          <= tmo_d;
         sd_addr_q      <= sd_addr_d;
         sd_din_q       <= sd_din_d;
         sd_rd_q        <= sd_rd_d;
         sd_we_q        <= sd_we_d;
         rd_data_q      <= rd_data_d;
         rd_valid_q     <= rd_valid_d;
         err_timeout_q  <= err_timeout_d;
         err_overflow_q <= err_overflow_d;
      end
   end

   assign wr_wait      = wr_full_s;
   assign rd_busy      = rd_full_s;
   assign rd_data      = rd_data_q;
   assign rd_valid     = rd_valid_q;
   assign sd_addr      = sd_addr_q;
   assign sd_din       = sd_din_q;
   assign sd_rd        = sd_rd_q;
   assign sd_we        = sd_we_q;
   assign err_timeout  = err_timeout_q;
   assign err_overflow = err_overflow_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: read/write latency, write-burst limit,
// watchdog abort, overflow handling and asynchronous reset mid-transaction.
module tb_sdram_arbiter;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        wr_req = 1'b0;
   logic [24:0] wr_addr = '0;
   logic [7:0]  wr_data = '0;
   logic        wr_wait;
   logic        rd_req = 1'b0;
   logic [24:0] rd_addr = '0;
   logic [7:0]  rd_data;
   logic        rd_valid;
   logic        rd_busy;
   logic [24:0] sd_addr;
   logic [7:0]  sd_din;
   logic        sd_rd;
   logic        sd_we;
   logic [7:0]  sd_dout = '0;
   logic        sd_ready = 1'b0;
   logic        err_timeout;
   logic        err_overflow;
   logic        err_clr = 1'b0;

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   sdram_arbiter dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .wr_req       (wr_req),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .wr_wait      (wr_wait),
      .rd_req       (rd_req),
      .rd_addr      (rd_addr),
      .rd_data      (rd_data),
      .rd_valid     (rd_valid),
      .rd_busy      (rd_busy),
      .sd_addr      (sd_addr),
      .sd_din       (sd_din),
      .sd_rd        (sd_rd),
      .sd_we        (sd_we),
      .sd_dout      (sd_dout),
      .sd_ready     (sd_ready),
      .err_timeout  (err_timeout),
      .err_overflow (err_overflow),
      .err_clr      (err_clr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int starve_exp [7] = '{0, 1, 2, 3, 4, 0, 0};
      int we_cnt;
      int rv_cnt;

      // ---------------- reset state ----------------
      reset_n = 1'b0;
      step();
      chk("rst_sd_rd",    32'(sd_rd),        32'h0);
      chk("rst_sd_we",    32'(sd_we),        32'h0);
      chk("rst_wr_wait",  32'(wr_wait),      32'h0);
      chk("rst_rd_busy",  32'(rd_busy),      32'h0);
      chk("rst_rd_valid", 32'(rd_valid),     32'h0);
      chk("rst_rd_data",  32'(rd_data),      32'h0);
      chk("rst_sd_addr",  32'(sd_addr),      32'h0);
      chk("rst_err_tmo",  32'(err_timeout),  32'h0);
      chk("rst_err_ovf",  32'(err_overflow), 32'h0);
      step();
      reset_n = 1'b1;
      step();

      // ---------------- single read ----------------
      rd_req = 1'b1; rd_addr = 25'h12345;
      step();
      rd_req = 1'b0; rd_addr = '0;
      chk("rd_busy_rise", 32'(rd_busy), 32'h1);
      chk("rd_no_early",  32'(sd_rd),   32'h0);
      step();
      chk("rd_strobe",    32'(sd_rd),   32'h1);
      chk("rd_addr",      32'(sd_addr), 32'h12345);
      chk("rd_no_we",     32'(sd_we),   32'h0);
      step();
      chk("rd_strobe_1c", 32'(sd_rd),   32'h0);
      step();
      step();
      sd_ready = 1'b1; sd_dout = 8'hA5;
      chk("rd_valid_pre", 32'(rd_valid), 32'h0);
      step();
      sd_ready = 1'b0; sd_dout = 8'h00;
      chk("rd_valid",     32'(rd_valid), 32'h1);
      chk("rd_data",      32'(rd_data),  32'hA5);
      chk("rd_busy_fall", 32'(rd_busy),  32'h0);
      step();
      chk("rd_valid_1c",  32'(rd_valid), 32'h0);
      chk("rd_data_hold", 32'(rd_data),  32'hA5);

      // ---------------- single write ----------------
      wr_req = 1'b1; wr_addr = 25'h4B000; wr_data = 8'h3C;
      step();
      wr_req = 1'b0; wr_addr = '0; wr_data = '0;
      chk("wr_wait_rise", 32'(wr_wait), 32'h1);
      step();
      chk("wr_strobe",    32'(sd_we),   32'h1);
      chk("wr_din",       32'(sd_din),  32'h3C);
      chk("wr_addr",      32'(sd_addr), 32'h4B000);
      step();
      chk("wr_strobe_1c", 32'(sd_we),   32'h0);
      chk("wr_din_hold",  32'(sd_din),  32'h3C);
      step();
      sd_ready = 1'b1;
      chk("wr_wait_held", 32'(wr_wait), 32'h1);
      step();
      sd_ready = 1'b0;
      chk("wr_wait_fall", 32'(wr_wait), 32'h0);

      // ---------------- write starvation limit ----------------
      // Each write takes 4 cycles (grant, issue, wait, wait+ready) and the
      // next write arrives in the ready cycle, so a write is always pending.
      wr_req = 1'b1; wr_addr = 25'h00200; wr_data = 8'h10;
      step();
      wr_req = 1'b0;
      for (int i = 0; i < 7; i++) begin
         if (i == 6) begin
            chk("starve_rd_valid", 32'(rd_valid), 32'h1);
            chk("starve_rd_data",  32'(rd_data),  32'h5A);
         end
         step();
         chk($sformatf("starve_we_%0d", i), 32'(sd_we), (i != 5) ? 32'h1 : 32'h0);
         chk($sformatf("starve_rd_%0d", i), 32'(sd_rd), (i == 5) ? 32'h1 : 32'h0);
         chk($sformatf("starve_cnt_%0d", i), 32'(dut.starve_q), 32'(starve_exp[i]));
         if (i == 0) begin
            rd_req = 1'b1; rd_addr = 25'h00BEE;
         end
         step();
         rd_req = 1'b0;
         step();
         sd_ready = 1'b1;
         sd_dout  = (i == 5) ? 8'h5A : 8'h00;
         if (i < 5) begin
            wr_req = 1'b1; wr_addr = 25'(32'h201 + i); wr_data = 8'(8'h11 + i);
         end
         step();
         sd_ready = 1'b0; sd_dout = '0; wr_req = 1'b0;
      end
      chk("starve_no_ovf",  32'(err_overflow), 32'h0);
      chk("starve_wr_idle", 32'(wr_wait),      32'h0);
      chk("starve_rd_idle", 32'(rd_busy),      32'h0);

      // ---------------- timeout ----------------
      rd_req = 1'b1; rd_addr = 25'h00777;
      step();
      rd_req = 1'b0;
      step();
      chk("tmo_rd_strobe", 32'(sd_rd), 32'h1);
      repeat (255) step();
      chk("tmo_early_valid", 32'(rd_valid),    32'h0);
      chk("tmo_early_err",   32'(err_timeout), 32'h0);
      chk("tmo_busy_held",   32'(rd_busy),     32'h1);
      step();
      chk("tmo_rd_valid", 32'(rd_valid),    32'h1);
      chk("tmo_rd_data",  32'(rd_data),     32'h0);
      chk("tmo_err",      32'(err_timeout), 32'h1);
      chk("tmo_busy",     32'(rd_busy),     32'h0);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      chk("tmo_err_clr", 32'(err_timeout), 32'h0);
      // A stray completion while idle must be ignored.
      sd_ready = 1'b1; sd_dout = 8'hFF;
      step();
      sd_ready = 1'b0; sd_dout = '0;
      chk("stray_ready_valid", 32'(rd_valid), 32'h0);
      chk("stray_ready_data",  32'(rd_data),  32'h0);

      // ---------------- overflow ----------------
      we_cnt = 0;
      wr_req = 1'b1; wr_addr = 25'h00100; wr_data = 8'h11;
      step();
      wr_req = 1'b0;
      chk("ovf_wait",   32'(wr_wait),      32'h1);
      chk("ovf_no_err", 32'(err_overflow), 32'h0);
      step();
      we_cnt += int'(sd_we);
      wr_req = 1'b1; wr_addr = 25'h00200; wr_data = 8'h22;
      step();
      wr_req = 1'b0;
      we_cnt += int'(sd_we);
      chk("ovf_err",      32'(err_overflow), 32'h1);
      chk("ovf_din_kept", 32'(sd_din),       32'h11);
      step();
      we_cnt += int'(sd_we);
      sd_ready = 1'b1;
      step();
      sd_ready = 1'b0;
      chk("ovf_wait_fall", 32'(wr_wait), 32'h0);
      for (int k = 0; k < 6; k++) begin
         we_cnt += int'(sd_we);
         step();
      end
      chk("ovf_one_we", 32'(we_cnt), 32'h1);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      chk("ovf_err_clr", 32'(err_overflow), 32'h0);

      // ---------------- reset during WAIT ----------------
      rd_req = 1'b1; rd_addr = 25'h0ABCD;
      step();
      rd_req = 1'b0;
      wr_req = 1'b1; wr_addr = 25'h01000; wr_data = 8'h77;
      step();
      wr_req = 1'b0;
      chk("mid_rd_strobe", 32'(sd_rd), 32'h1);
      step();
      chk("mid_rd_busy", 32'(rd_busy), 32'h1);
      chk("mid_wr_wait", 32'(wr_wait), 32'h1);
      #2;
      reset_n = 1'b0;
      sd_ready = 1'b1; sd_dout = 8'hEE;
      #1;
      chk("async_sd_rd",   32'(sd_rd),   32'h0);
      chk("async_sd_we",   32'(sd_we),   32'h0);
      chk("async_wr_wait", 32'(wr_wait), 32'h0);
      chk("async_rd_busy", 32'(rd_busy), 32'h0);
      step();
      step();
      sd_ready = 1'b0; sd_dout = '0;
      reset_n = 1'b1;
      rv_cnt = 0;
      we_cnt = 0;
      for (int k = 0; k < 4; k++) begin
         step();
         rv_cnt += int'(rd_valid);
         we_cnt += int'(sd_we);
      end
      chk("post_rst_no_valid", 32'(rv_cnt), 32'h0);
      chk("post_rst_no_we",    32'(we_cnt), 32'h0);
      rd_req = 1'b1; rd_addr = 25'h00042;
      step();
      rd_req = 1'b0;
      chk("post_rst_no_early", 32'(sd_rd), 32'h0);
      step();
      chk("post_rst_rd",   32'(sd_rd),   32'h1);
      chk("post_rst_addr", 32'(sd_addr), 32'h42);
      step();
      sd_ready = 1'b1; sd_dout = 8'hC3;
      step();
      sd_ready = 1'b0; sd_dout = '0;
      chk("post_rst_valid", 32'(rd_valid), 32'h1);
      chk("post_rst_data",  32'(rd_data),  32'hC3);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
